// File: rtl/elastic_pipe_stage_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : elastic_pipe_stage_if                                      |
// | Description : Valid/ready handshake bundle between two pipeline stages.  |
// |               The slave modport is the stage itself. The master modport  |
// |               is the environment around it: the upstream producer plus   |
// |               the downstream consumer.                                   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface elastic_pipe_stage_if #(
   parameter int DATA_W = 32
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [1:0]        occupancy;

   // Environment view: feeds upstream payload and downstream ready.
   modport master (
      output in_valid,
      output in_data,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_data,
      input  occupancy
   );

   // Stage view.
   modport slave (
      input  in_valid,
      input  in_data,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_data,
      output occupancy
   );
endinterface : elastic_pipe_stage_if
`default_nettype wire

// File: rtl/elastic_pipe_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : elastic_pipe_stage                                         |
// | Description : Inter-stage pipeline register with valid/ready handshake.  |
// |               SKID=1 adds a second entry so that in_ready comes from a   |
// |               flop. SKID=0 holds one entry and in_ready is combinational.|
// |               A synchronous flush squashes every held entry.             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module elastic_pipe_stage #(
   parameter int DATA_W         = 32,
   parameter int SKID           = 1,
   parameter int CLEAR_ON_FLUSH = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 flush,
   elastic_pipe_stage_if.slave  bus
);

   // The encoding equals the number of held entries, so occupancy is the state.
   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_FULL  = 2'd1,
      S_SKID  = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [DATA_W-1:0] r_main;
   logic [DATA_W-1:0] w_main_nxt;
   logic [DATA_W-1:0] r_skid;
   logic [DATA_W-1:0] w_skid_nxt;

   logic              w_in_ready;
   logic              w_out_valid;
   logic              w_in_fire;
   logic              w_out_fire;

   assign w_out_valid = (r_state != S_EMPTY);
   assign w_in_fire   = bus.in_valid & w_in_ready;
   assign w_out_fire  = w_out_valid & bus.out_ready;

   generate
      if (SKID != 0) begin : g_skid_ready
         logic r_in_rdy;

         // Ready flop: low only while the skid entry is occupied.
         always_ff @(posedge clk) begin
            if (reset) begin
               r_in_rdy <= 1'b1;
            end else begin
               r_in_rdy <= (w_state_nxt != S_SKID);
            end
         end

         // Reset and flush still gate the flopped ready within the same cycle.
         assign w_in_ready = r_in_rdy & ~reset & ~flush;
      end else begin : g_comb_ready
         // With one entry, a slot opens in the same cycle that the head leaves.
         assign w_in_ready = ~reset & ~flush & (~w_out_valid | bus.out_ready);
      end
   endgenerate

   // Next-state and datapath selection. Flush overrides any handshake.
   always_comb begin
      w_state_nxt = r_state;
      w_main_nxt  = r_main;
      w_skid_nxt  = r_skid;
      if (flush) begin
         // A head that leaves during a flush has already been delivered.
         // Everything still held is dropped.
         w_state_nxt = S_EMPTY;
         if (CLEAR_ON_FLUSH != 0) begin
            w_main_nxt = '0;
            w_skid_nxt = '0;
         end
      end else begin
         case (r_state)
            S_EMPTY: begin
               if (w_in_fire) begin
                  w_state_nxt = S_FULL;
                  w_main_nxt  = bus.in_data;
               end
            end
            S_FULL: begin
               if (w_in_fire && w_out_fire) begin
                  w_main_nxt = bus.in_data;
               end else if (w_out_fire) begin
                  w_state_nxt = S_EMPTY;
               end else if (w_in_fire && (SKID != 0)) begin
                  // Head is stalled, so the new payload parks behind it.
                  w_state_nxt = S_SKID;
                  w_skid_nxt  = bus.in_data;
               end
            end
            S_SKID: begin
               if (w_out_fire) begin
                  w_state_nxt = S_FULL;
                  w_main_nxt  = r_skid;
               end
            end
            default: begin
               w_state_nxt = S_EMPTY;
            end
         endcase
      end
   end

   // State and payload registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_EMPTY;
         r_main  <= '0;
         r_skid  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_main  <= w_main_nxt;
         r_skid  <= w_skid_nxt;
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_out_valid;
   assign bus.out_data  = r_main;
   assign bus.occupancy = r_state;

endmodule : elastic_pipe_stage
`default_nettype wire

// File: tb/tb_elastic_pipe_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_elastic_pipe_stage                                      |
// | Description : Directed vectors plus a random valid/ready run with a      |
// |               reference queue model. Four configurations:                |
// |               a=32b/SKID1/CLR1, b=32b/SKID0/CLR0, c=97b/SKID1/CLR0,      |
// |               d=1b/SKID0/CLR1.                                           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_elastic_pipe_stage;

   logic clk = 1'b0;
   logic reset;
   logic flush;

   always #5 clk = ~clk;

   elastic_pipe_stage_if #(.DATA_W(32)) ifa ();
   elastic_pipe_stage_if #(.DATA_W(32)) ifb ();
   elastic_pipe_stage_if #(.DATA_W(97)) ifc ();
   elastic_pipe_stage_if #(.DATA_W(1))  ifd ();

   elastic_pipe_stage #(.DATA_W(32), .SKID(1), .CLEAR_ON_FLUSH(1)) u_a (
      .clk(clk), .reset(reset), .flush(flush), .bus(ifa.slave));
   elastic_pipe_stage #(.DATA_W(32), .SKID(0), .CLEAR_ON_FLUSH(0)) u_b (
      .clk(clk), .reset(reset), .flush(flush), .bus(ifb.slave));
   elastic_pipe_stage #(.DATA_W(97), .SKID(1), .CLEAR_ON_FLUSH(0)) u_c (
      .clk(clk), .reset(reset), .flush(flush), .bus(ifc.slave));
   elastic_pipe_stage #(.DATA_W(1), .SKID(0), .CLEAR_ON_FLUSH(1)) u_d (
      .clk(clk), .reset(reset), .flush(flush), .bus(ifd.slave));

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One cycle on stage a: drive after the edge, check at the falling edge.
   task automatic vec_a(input string tag, input logic iv, input logic [31:0] d, input logic orr,
                        input logic fl, input logic e_rdy, input logic e_ov,
                        input logic [31:0] e_od, input logic [1:0] e_occ);
      @(posedge clk); #1;
      ifa.in_valid = iv; ifa.in_data = d; ifa.out_ready = orr; flush = fl;
      @(negedge clk);
      check_val({tag, "_rdy"}, 128'(ifa.in_ready), 128'(e_rdy));
      check_val({tag, "_ov"},  128'(ifa.out_valid), 128'(e_ov));
      check_val({tag, "_occ"}, 128'(ifa.occupancy), 128'(e_occ));
      if (e_ov) check_val({tag, "_od"}, 128'(ifa.out_data), 128'(e_od));
   endtask

   task automatic vec_b(input string tag, input logic iv, input logic [31:0] d, input logic orr,
                        input logic fl, input logic e_rdy, input logic e_ov,
                        input logic [31:0] e_od, input logic [1:0] e_occ);
      @(posedge clk); #1;
      ifb.in_valid = iv; ifb.in_data = d; ifb.out_ready = orr; flush = fl;
      @(negedge clk);
      check_val({tag, "_rdy"}, 128'(ifb.in_ready), 128'(e_rdy));
      check_val({tag, "_ov"},  128'(ifb.out_valid), 128'(e_ov));
      check_val({tag, "_occ"}, 128'(ifb.occupancy), 128'(e_occ));
      if (e_ov) check_val({tag, "_od"}, 128'(ifb.out_data), 128'(e_od));
   endtask

   // Reference model: up to two queued entries per stage.
   logic [127:0] m_e0 [4];
   logic [127:0] m_e1 [4];
   int           m_cnt[4];

   task automatic model_step(input int k, input bit skid, input logic iv, input logic ir,
                             input logic [127:0] id, input logic ov, input logic orr,
                             input logic [127:0] od, input logic [1:0] occ);
      logic e_rdy;
      e_rdy = skid ? (m_cnt[k] < 2) : ((m_cnt[k] == 0) || orr);
      check_val($sformatf("rnd%0d_rdy", k), 128'(ir), 128'(e_rdy));
      check_val($sformatf("rnd%0d_ov", k), 128'(ov), 128'(m_cnt[k] != 0));
      check_val($sformatf("rnd%0d_occ", k), 128'(occ), 128'(m_cnt[k]));
      if (m_cnt[k] != 0) check_val($sformatf("rnd%0d_od", k), od, m_e0[k]);
      if ((m_cnt[k] != 0) && orr) begin
         m_e0[k] = m_e1[k];
         m_cnt[k]--;
      end
      if (iv && e_rdy) begin
         if (m_cnt[k] == 0) m_e0[k] = id;
         else               m_e1[k] = id;
         m_cnt[k]++;
      end
   endtask

   initial begin
      logic [127:0] rnd;
      reset = 1'b1; flush = 1'b0;
      ifa.in_valid = 1'b1; ifa.in_data = 32'hDEAD; ifa.out_ready = 1'b0;
      ifb.in_valid = 1'b1; ifb.in_data = 32'hBEEF; ifb.out_ready = 1'b0;
      ifc.in_valid = 1'b0; ifc.in_data = '0; ifc.out_ready = 1'b0;
      ifd.in_valid = 1'b0; ifd.in_data = '0; ifd.out_ready = 1'b0;

      // Reset held two cycles with in_valid high.
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_a_rdy", 128'(ifa.in_ready), 128'(0));
      check_val("rst_b_rdy", 128'(ifb.in_ready), 128'(0));
      check_val("rst_a_ov",  128'(ifa.out_valid), 128'(0));
      check_val("rst_a_od",  128'(ifa.out_data), 128'(0));
      check_val("rst_a_occ", 128'(ifa.occupancy), 128'(0));
      check_val("rst_b_od",  128'(ifb.out_data), 128'(0));
      reset = 1'b0; ifa.in_valid = 1'b0; ifb.in_valid = 1'b0;
      @(negedge clk);
      check_val("rel_a_rdy", 128'(ifa.in_ready), 128'(1));
      check_val("rel_b_rdy", 128'(ifb.in_ready), 128'(1));

      // Streaming 0x1..0x10 through a and b.
      for (int i = 1; i <= 16; i++) begin
         @(posedge clk); #1;
         ifa.in_valid = 1'b1; ifa.in_data = 32'(i); ifa.out_ready = 1'b1;
         ifb.in_valid = 1'b1; ifb.in_data = 32'(i); ifb.out_ready = 1'b1;
         @(negedge clk);
         check_val("str_a_rdy", 128'(ifa.in_ready), 128'(1));
         check_val("str_b_rdy", 128'(ifb.in_ready), 128'(1));
         check_val("str_a_ov", 128'(ifa.out_valid), 128'(i > 1));
         check_val("str_b_ov", 128'(ifb.out_valid), 128'(i > 1));
         if (i > 1) begin
            check_val("str_a_od", 128'(ifa.out_data), 128'(i - 1));
            check_val("str_b_od", 128'(ifb.out_data), 128'(i - 1));
            check_val("str_a_occ", 128'(ifa.occupancy), 128'(1));
         end
      end
      @(posedge clk); #1;
      ifa.in_valid = 1'b0; ifb.in_valid = 1'b0;
      @(negedge clk);
      check_val("str_a_last", 128'(ifa.out_data), 128'(16));
      check_val("str_b_last", 128'(ifb.out_data), 128'(16));
      vec_a("str_a_drain", 0, 0, 1, 0, 1, 0, 0, 0);

      // Backpressure on the skid stage: A,B,C with out_ready low.
      vec_a("bp1", 1, 32'hA, 0, 0, 1, 0, 0,     0);
      vec_a("bp2", 1, 32'hB, 0, 0, 1, 1, 32'hA, 1);
      vec_a("bp3", 1, 32'hC, 0, 0, 0, 1, 32'hA, 2);
      vec_a("bp4", 1, 32'hC, 1, 0, 0, 1, 32'hA, 2);
      vec_a("bp5", 1, 32'hC, 1, 0, 1, 1, 32'hB, 1);
      vec_a("bp6", 0, 0,     1, 0, 1, 1, 32'hC, 1);
      vec_a("bp7", 0, 0,     1, 0, 1, 0, 0,     0);

      // Flush with two entries held; the head still leaves in the flush cycle.
      vec_a("fl1", 1, 32'h11, 0, 0, 1, 0, 0,      0);
      vec_a("fl2", 1, 32'h22, 0, 0, 1, 1, 32'h11, 1);
      vec_a("fl3", 0, 0,      0, 0, 0, 1, 32'h11, 2);
      vec_a("fl4", 1, 32'h33, 1, 1, 0, 1, 32'h11, 2);
      vec_a("fl5", 0, 0,      1, 0, 1, 0, 0,      0);
      check_val("fl5_cleared", 128'(ifa.out_data), 128'(0));
      vec_a("fl6", 0, 0,      1, 0, 1, 0, 0,      0);
      // Flush while empty, back to back, with in_valid high.
      vec_a("fe1", 1, 32'h44, 1, 1, 0, 0, 0, 0);
      vec_a("fe2", 1, 32'h45, 1, 1, 0, 0, 0, 0);
      vec_a("fe3", 0, 0,      1, 0, 1, 0, 0, 0);

      // Flush on the single-entry stage without clearing the data.
      vec_b("fb1", 1, 32'h55, 0, 0, 1, 0, 0,      0);
      vec_b("fb2", 0, 0,      0, 0, 0, 1, 32'h55, 1);
      vec_b("fb3", 0, 0,      0, 1, 0, 1, 32'h55, 1);
      vec_b("fb4", 0, 0,      0, 0, 1, 0, 0,      0);
      check_val("fb4_stale", 128'(ifb.out_data), 128'(32'h55));

      // Single-entry stage with out_ready toggling and in_valid held high.
      vec_b("tg1", 1, 32'h61, 1, 0, 1, 0, 0,      0);
      vec_b("tg2", 1, 32'h62, 0, 0, 0, 1, 32'h61, 1);
      vec_b("tg3", 1, 32'h62, 1, 0, 1, 1, 32'h61, 1);
      vec_b("tg4", 1, 32'h63, 0, 0, 0, 1, 32'h62, 1);
      vec_b("tg5", 1, 32'h63, 1, 0, 1, 1, 32'h62, 1);
      vec_b("tg6", 0, 0,      1, 0, 1, 1, 32'h63, 1);
      vec_b("tg7", 0, 0,      1, 0, 1, 0, 0,      0);

      // Random valid/ready on all four stages against the queue model.
      @(posedge clk); #1;
      reset = 1'b1;
      ifa.in_valid = 1'b0; ifb.in_valid = 1'b0; ifc.in_valid = 1'b0; ifd.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         m_cnt[k] = 0; m_e0[k] = '0; m_e1[k] = '0;
      end
      for (int cyc = 0; cyc < 600; cyc++) begin
         int rp;
         rp = (cyc < 300) ? 3 : 1;
         if (cyc != 0) begin
            @(posedge clk); #1;
         end
         ifa.in_valid = ($urandom_range(0, 3) != 0); ifa.in_data = $urandom;
         ifa.out_ready = ($urandom_range(0, 3) < rp);
         ifb.in_valid = ($urandom_range(0, 3) != 0); ifb.in_data = $urandom;
         ifb.out_ready = ($urandom_range(0, 3) < rp);
         rnd = {$urandom, $urandom, $urandom, $urandom};
         ifc.in_valid = ($urandom_range(0, 3) != 0); ifc.in_data = rnd[96:0];
         ifc.out_ready = ($urandom_range(0, 3) < rp);
         ifd.in_valid = ($urandom_range(0, 3) != 0); ifd.in_data = 1'($urandom);
         ifd.out_ready = ($urandom_range(0, 3) < rp);
         @(negedge clk);
         model_step(0, 1'b1, ifa.in_valid, ifa.in_ready, 128'(ifa.in_data),
                    ifa.out_valid, ifa.out_ready, 128'(ifa.out_data), ifa.occupancy);
         model_step(1, 1'b0, ifb.in_valid, ifb.in_ready, 128'(ifb.in_data),
                    ifb.out_valid, ifb.out_ready, 128'(ifb.out_data), ifb.occupancy);
         model_step(2, 1'b1, ifc.in_valid, ifc.in_ready, 128'(ifc.in_data),
                    ifc.out_valid, ifc.out_ready, 128'(ifc.out_data), ifc.occupancy);
         model_step(3, 1'b0, ifd.in_valid, ifd.in_ready, 128'(ifd.in_data),
                    ifd.out_valid, ifd.out_ready, 128'(ifd.out_data), ifd.occupancy);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_elastic_pipe_stage
`default_nettype wire
